// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: control/decode <-> program-counter unit signal bundle
interface pc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             exc;
    logic             branch;
    logic             jump;
    logic             jreg;
    logic             ret;
    logic             call;
    logic [WIDTH-1:0] pc_offset;
    logic [WIDTH-1:0] pc_jmp;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_udf;
    logic             sel_err;

    modport master (
        output stall, exc, branch, jump, jreg, ret, call, pc_offset, pc_jmp, pc_reg,
        input  pc, pc_next, epc, ras_empty, ras_full, ras_ovf, ras_udf, sel_err
    );

    modport slave (
        input  stall, exc, branch, jump, jreg, ret, call, pc_offset, pc_jmp, pc_reg,
        output pc, pc_next, epc, ras_empty, ras_full, ras_ovf, ras_udf, sel_err
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-address register with branch/jump/exception vectoring and a circular return-address stack
module pc_ctrl #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
    parameter int               RAS_DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    pc_ctrl_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_r, epc_r, pc_inc, pc_next, ret_tgt;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    tp, wa;
    logic [CW-1:0]    cnt;
    logic [2:0]       n_sel;
    logic             sel_bad, act, push, pop, empty, full, ovf_r, udf_r, sel_err_r;

    assign pc_inc  = pc_r + WIDTH'(STEP);
    assign n_sel   = 3'(bus.branch) + 3'(bus.jump) + 3'(bus.jreg) + 3'(bus.ret);
    assign sel_bad = n_sel > 3'd1;
    assign act     = !bus.exc && !bus.stall && !sel_bad;
    assign push    = act && bus.call;
    assign pop     = act && bus.ret;
    assign empty   = cnt == '0;
    assign full    = cnt == CW'(RAS_DEPTH);
    assign ret_tgt = empty ? bus.pc_reg : ras[tp];
    // a call paired with a pop of a live entry replaces the top instead of stacking above it
    assign wa      = (pop && !empty) ? tp : tp + PW'(1);

    // next fetch address: exception first, then hold (stall or bad select), then the single select
    always_comb begin
        pc_next = bus.exc ? EXC_VEC :
                  (bus.stall || sel_bad) ? pc_r :
                  bus.branch ? pc_inc + bus.pc_offset :
                  bus.jump ? bus.pc_jmp :
                  bus.jreg ? bus.pc_reg :
                  bus.ret ? ret_tgt : pc_inc;
    end

    // pc, exception pc and select-error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= RESET_VEC;
            epc_r     <= '0;
            sel_err_r <= 1'b0;
        end else begin
            pc_r      <= pc_next;
            if (bus.exc)
                epc_r <= pc_r;
            sel_err_r <= !bus.exc && !bus.stall && sel_bad;
        end
    end

    // RAS pointer, occupancy and sticky error flags; a push while full wraps onto the oldest entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp    <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (push && pop) begin
            if (empty) begin
                tp    <= tp + PW'(1);
                cnt   <= CW'(1);
                udf_r <= 1'b1;
            end
        end else if (push) begin
            tp <= tp + PW'(1);
            if (full)
                ovf_r <= 1'b1;
            else
                cnt <= cnt + CW'(1);
        end else if (pop) begin
            if (empty) begin
                udf_r <= 1'b1;
            end else begin
                tp  <= tp - PW'(1);
                cnt <= cnt - CW'(1);
            end
        end
    end

    // RAS storage; entries need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push)
            ras[wa] <= pc_inc;
    end

    assign bus.pc        = pc_r;
    assign bus.pc_next   = pc_next;
    assign bus.epc       = epc_r;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_ovf   = ovf_r;
    assign bus.ras_udf   = udf_r;
    assign bus.sel_err   = sel_err_r;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench for pc_ctrl (word-addressed and byte-addressed builds)
module tb_pc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] links[$];
    logic [31:0] e;

    pc_ctrl_if #(.WIDTH(32)) i();
    pc_ctrl_if #(.WIDTH(32)) i4();

    pc_ctrl #(.WIDTH(32), .STEP(1), .RESET_VEC(32'd0), .EXC_VEC(32'h80), .RAS_DEPTH(4))
        dut (.clk(clk), .rst(rst), .bus(i));
    pc_ctrl #(.WIDTH(32), .STEP(4), .RESET_VEC(32'd0), .EXC_VEC(32'h80), .RAS_DEPTH(4))
        dut4 (.clk(clk), .rst(rst), .bus(i4));

    always #5 clk = ~clk;

    task idle();
        {i.stall, i.exc, i.branch, i.jump, i.jreg, i.ret, i.call} = '0;
        {i4.stall, i4.exc, i4.branch, i4.jump, i4.jreg, i4.ret, i4.call} = '0;
        i.pc_offset = '0; i.pc_jmp = '0; i.pc_reg = '0;
        i4.pc_offset = '0; i4.pc_jmp = '0; i4.pc_reg = '0;
    endtask

    task go();
        @(posedge clk); #1;
        idle();
    endtask

    task test_reset();
        idle();
        rst = 1'b0;
        #2;
        checks++; if (i.pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", i.pc); end
        checks++; if (i.epc !== 32'd0) begin errors++; $display("FAIL reset_epc got=%0h exp=0", i.epc); end
        checks++; if ({i.ras_empty, i.ras_full, i.ras_ovf, i.ras_udf, i.sel_err} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got=%b exp=10000", {i.ras_empty, i.ras_full, i.ras_ovf, i.ras_udf, i.sel_err}); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (i.pc_next !== 32'd1) begin errors++; $display("FAIL reset_pc_next got=%0h exp=1", i.pc_next); end
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(32'(k));
            go();
            e = exp_q.pop_front();
            checks++; if (i.pc !== e) begin errors++; $display("FAIL free_run_pc got=%0h exp=%0h", i.pc, e); end
            checks++; if (i.pc_next !== e + 1) begin errors++; $display("FAIL free_run_pc_next got=%0h exp=%0h", i.pc_next, e + 1); end
        end
    endtask

    task test_branch_jump();
        i.jump = 1'b1; i.pc_jmp = 32'd10; exp_q.push_back(32'd10); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL jump10 got=%0h exp=%0h", i.pc, e); end
        i.branch = 1'b1; i.pc_offset = 32'hFFFF_FFFD; exp_q.push_back(32'd8); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL branch_neg got=%0h exp=%0h", i.pc, e); end
        i.jump = 1'b1; i.pc_jmp = 32'd10; exp_q.push_back(32'd10); go();
        i.jump = 1'b1; i.pc_jmp = 32'h40; exp_q.push_back(32'h40); go();
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL jump40 got=%0h exp=%0h", i.pc, e); end
        i.jreg = 1'b1; i.pc_reg = 32'h1234; exp_q.push_back(32'h1234); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL jreg got=%0h exp=%0h", i.pc, e); end
    endtask

    task test_call_ret();
        i.jump = 1'b1; i.pc_jmp = 32'd5; go();
        i.call = 1'b1; i.jump = 1'b1; i.pc_jmp = 32'd20; exp_q.push_back(32'd20); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL call_jump got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.ras_empty !== 1'b0) begin errors++; $display("FAIL call_not_empty got=%b exp=0", i.ras_empty); end
        i.jump = 1'b1; i.pc_jmp = 32'd23; go();
        i.ret = 1'b1; i.pc_reg = 32'd77; exp_q.push_back(32'd6); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL ret_link got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b exp=1", i.ras_empty); end
    endtask

    task test_ras_overflow();
        i.jump = 1'b1; i.pc_jmp = 32'h200; go();
        for (int k = 0; k < 5; k++) begin
            i.call = 1'b1; i.jump = 1'b1; i.pc_jmp = 32'h300 + 32'(16 * k);
            links.push_back(k == 0 ? 32'h201 : 32'h300 + 32'(16 * (k - 1)) + 32'd1);
            exp_q.push_back(32'h300 + 32'(16 * k));
            go();
            e = exp_q.pop_front();
            checks++; if (i.pc !== e) begin errors++; $display("FAIL ovf_call_pc got=%0h exp=%0h", i.pc, e); end
            checks++; if (i.ras_full !== (k >= 3)) begin errors++; $display("FAIL ovf_full k=%0d got=%b", k, i.ras_full); end
            checks++; if (i.ras_ovf !== (k == 4)) begin errors++; $display("FAIL ovf_flag k=%0d got=%b", k, i.ras_ovf); end
        end
        for (int k = 0; k < 4; k++) begin
            i.ret = 1'b1; i.pc_reg = 32'hDEAD; exp_q.push_back(links.pop_back()); go();
            e = exp_q.pop_front();
            checks++; if (i.pc !== e) begin errors++; $display("FAIL ovf_ret%0d got=%0h exp=%0h", k, i.pc, e); end
        end
        links.delete();
        checks++; if ({i.ras_empty, i.ras_ovf, i.ras_udf} !== 3'b110) begin
            errors++; $display("FAIL drained_flags got=%b exp=110", {i.ras_empty, i.ras_ovf, i.ras_udf}); end
        i.ret = 1'b1; i.pc_reg = 32'd99; exp_q.push_back(32'd99); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL udf_ret got=%0h exp=%0h", i.pc, e); end
        checks++; if ({i.ras_empty, i.ras_udf} !== 2'b11) begin
            errors++; $display("FAIL udf_flags got=%b exp=11", {i.ras_empty, i.ras_udf}); end
    endtask

    task test_back_to_back();
        i.call = 1'b1; i.jump = 1'b1; i.pc_jmp = 32'h400; exp_q.push_back(32'h400); go();
        i.call = 1'b1; i.ret = 1'b1; i.pc_reg = 32'd7; exp_q.push_back(32'd100); go();
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL call_ret_pc got=%0h exp=%0h", i.pc, e); end
        checks++; if ({i.ras_empty, i.ras_full} !== 2'b00) begin
            errors++; $display("FAIL call_ret_count got=%b exp=00", {i.ras_empty, i.ras_full}); end
        i.ret = 1'b1; exp_q.push_back(32'h401); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL call_ret_top got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.ras_empty !== 1'b1) begin errors++; $display("FAIL call_ret_empty got=%b exp=1", i.ras_empty); end
    endtask

    task test_stall_exc();
        i.jump = 1'b1; i.pc_jmp = 32'd7; go();
        i.stall = 1'b1; i.branch = 1'b1; i.pc_offset = 32'd5; i.call = 1'b1; #1;
        checks++; if (i.pc_next !== 32'd7) begin errors++; $display("FAIL stall_pc_next got=%0h exp=7", i.pc_next); end
        exp_q.push_back(32'd7); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL stall_pc got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.ras_empty !== 1'b1) begin errors++; $display("FAIL stall_call got=%b exp=1", i.ras_empty); end
        i.exc = 1'b1; i.stall = 1'b1; i.call = 1'b1; exp_q.push_back(32'h80); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL exc_pc got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.epc !== 32'd7) begin errors++; $display("FAIL exc_epc got=%0h exp=7", i.epc); end
        checks++; if (i.ras_empty !== 1'b1) begin errors++; $display("FAIL exc_call got=%b exp=1", i.ras_empty); end
        i.jump = 1'b1; i.jreg = 1'b1; i.pc_jmp = 32'd1; i.pc_reg = 32'd2; exp_q.push_back(32'h80); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL sel_hold got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_set got=%b exp=1", i.sel_err); end
        exp_q.push_back(32'h81); go();
        e = exp_q.pop_front();
        checks++; if (i.pc !== e) begin errors++; $display("FAIL sel_after got=%0h exp=%0h", i.pc, e); end
        checks++; if (i.sel_err !== 1'b0) begin errors++; $display("FAIL sel_err_clear got=%b exp=0", i.sel_err); end
    endtask

    task test_async_reset();
        i.call = 1'b1; i.jump = 1'b1; i.pc_jmp = 32'h500; go();
        i.call = 1'b1; i.jump = 1'b1; i.pc_jmp = 32'h600; go();
        checks++; if (i.ras_empty !== 1'b0) begin errors++; $display("FAIL pre_reset_empty got=%b exp=0", i.ras_empty); end
        #2 rst = 1'b0; #1;
        checks++; if (i.pc !== 32'd0) begin errors++; $display("FAIL async_pc got=%0h exp=0", i.pc); end
        checks++; if ({i.ras_empty, i.ras_ovf, i.ras_udf} !== 3'b100) begin
            errors++; $display("FAIL async_flags got=%b exp=100", {i.ras_empty, i.ras_ovf, i.ras_udf}); end
        checks++; if (i.epc !== 32'd0) begin errors++; $display("FAIL async_epc got=%0h exp=0", i.epc); end
    endtask

    task test_step4();
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (i4.pc !== 32'd0) begin errors++; $display("FAIL step4_reset got=%0h exp=0", i4.pc); end
        exp_q.push_back(32'd4); go();
        e = exp_q.pop_front();
        checks++; if (i4.pc !== e) begin errors++; $display("FAIL step4_pc1 got=%0h exp=%0h", i4.pc, e); end
        exp_q.push_back(32'd8); go();
        e = exp_q.pop_front();
        checks++; if (i4.pc !== e) begin errors++; $display("FAIL step4_pc2 got=%0h exp=%0h", i4.pc, e); end
        i4.call = 1'b1; i4.jump = 1'b1; i4.pc_jmp = 32'h100; exp_q.push_back(32'h100); go();
        e = exp_q.pop_front();
        checks++; if (i4.pc !== e) begin errors++; $display("FAIL step4_call got=%0h exp=%0h", i4.pc, e); end
        i4.ret = 1'b1; exp_q.push_back(32'd12); go();
        e = exp_q.pop_front();
        checks++; if (i4.pc !== e) begin errors++; $display("FAIL step4_link got=%0h exp=%0h", i4.pc, e); end
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_call_ret();
        test_ras_overflow();
        test_back_to_back();
        test_stall_exc();
        test_async_reset();
        test_step4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
